// File: rtl/flash_prog_seq.sv
// Flash programming sequencer: issues JEDEC byte-program / sector-erase command
// sequences from CCTL-mapped registers and completes them by DQ7 data polling.
module flash_prog_seq (
  input  logic        phi2,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [2:0]  reg_a,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [18:0] fl_a,
  output logic [7:0]  fl_dq_o,
  output logic        fl_dq_oe,
  input  logic [7:0]  fl_dq_i,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  output logic        fl_we_n
);

  typedef enum logic [2:0] {
    StIdle, StReq, StSetup, StWe, StHold, StPollRd, StPollChk, StFinish
  } state_e;

  localparam logic [7:0]  CmdErase = 8'h30;
  localparam logic [20:0] TmoMax   = '1;

  state_e      state_q, state_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        erase_q, erase_d;
  logic [2:0]  step_q, step_d;
  logic        dq7_q, dq7_d;
  logic        dq5_q, dq5_d;
  logic        dq5_seen_q, dq5_seen_d;
  logic [20:0] tmo_q, tmo_d;

  logic        bus_req_q, bus_req_d;
  logic [18:0] fl_a_q, fl_a_d;
  logic [7:0]  fl_dq_o_q, fl_dq_o_d;
  logic        fl_dq_oe_q, fl_dq_oe_d;
  logic        fl_ce_n_q, fl_ce_n_d;
  logic        fl_oe_n_q, fl_oe_n_d;
  logic        fl_we_n_q, fl_we_n_d;

  logic        wr_ok;
  logic        exp_dq7;
  logic [2:0]  last_step;
  logic [26:0] entry;
  logic        unused_dq;

  assign unused_dq = ^{fl_dq_i[6], fl_dq_i[4:0]};

  // {address, data} of one bus write within the command sequence
  function automatic logic [26:0] seq_entry(input logic        erase,
                                            input logic [2:0]  step,
                                            input logic [18:0] addr,
                                            input logic [7:0]  data);
    logic [18:0] a;
    logic [7:0]  d;
    a = '0;
    d = '0;
    if (erase) begin
      case (step)
        3'd0, 3'd3: begin a = 19'h05555; d = 8'hAA; end
        3'd1, 3'd4: begin a = 19'h02AAA; d = 8'h55; end
        3'd2:       begin a = 19'h05555; d = 8'h80; end
        default:    begin a = {addr[18:16], 16'h0000}; d = CmdErase; end
      endcase
    end else begin
      case (step)
        3'd0:    begin a = 19'h05555; d = 8'hAA; end
        3'd1:    begin a = 19'h02AAA; d = 8'h55; end
        3'd2:    begin a = 19'h05555; d = 8'hA0; end
        default: begin a = addr;      d = data;  end
      endcase
    end
    return {a, d};
  endfunction

  function automatic logic [18:0] poll_target(input logic erase, input logic [18:0] addr);
    return erase ? {addr[18:16], 16'h0000} : addr;
  endfunction

  assign wr_ok     = reg_wr && !busy_q;
  assign exp_dq7   = erase_q ? 1'b1 : data_q[7];
  assign last_step = erase_q ? 3'd5 : 3'd3;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = done_q;
    erase_d    = erase_q;
    step_d     = step_q;
    dq7_d      = dq7_q;
    dq5_d      = dq5_q;
    dq5_seen_d = dq5_seen_q;
    tmo_d      = tmo_q;

    if (reg_wr && reg_a == 3'd5 && reg_wdata[1]) err_d = 1'b0;

    if (wr_ok) begin
      case (reg_a)
        3'd0:    addr_d[7:0]   = reg_wdata;
        3'd1:    addr_d[15:8]  = reg_wdata;
        3'd2:    addr_d[18:16] = reg_wdata[2:0];
        3'd3:    data_d        = reg_wdata;
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (wr_ok && (reg_a == 3'd3 || (reg_a == 3'd4 && reg_wdata == CmdErase))) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          erase_d    = (reg_a == 3'd4);
          step_d     = 3'd0;
          dq5_seen_d = 1'b0;
          state_d    = StReq;
        end
      end
      StReq:   if (bus_gnt) state_d = StSetup;
      StSetup: state_d = StWe;
      StWe:    state_d = StHold;
      StHold: begin
        if (step_q == last_step) begin
          tmo_d   = '0;
          state_d = StPollRd;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = StSetup;
        end
      end
      StPollRd: begin
        dq7_d   = fl_dq_i[7];
        dq5_d   = fl_dq_i[5];
        if (tmo_q != TmoMax) tmo_d = tmo_q + 21'd1;
        state_d = StPollChk;
      end
      StPollChk: begin
        if (tmo_q != TmoMax) tmo_d = tmo_q + 21'd1;
        if (dq7_q == exp_dq7) begin
          done_d  = 1'b1;
          state_d = StFinish;
          if (!erase_q) addr_d = addr_q + 19'd1;
        end else if (dq5_seen_q || tmo_q == TmoMax) begin
          // DQ5 already granted its one confirming re-read, or polling ran out
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          dq5_seen_d = dq5_q;
          state_d    = StPollRd;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (!bus_gnt && state_q inside {StSetup, StWe, StHold, StPollRd, StPollChk}) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      addr_d  = addr_q;
      state_d = StFinish;
    end

    if (state_d == StFinish) busy_d = 1'b0;
  end

  // Outputs are decoded from the next state so they line up with state_q once registered.
  always_comb begin
    entry      = seq_entry(erase_d, step_d, addr_d, data_d);
    bus_req_d  = state_d inside {StReq, StSetup, StWe, StHold, StPollRd, StPollChk};
    fl_a_d     = '0;
    fl_dq_o_d  = '0;
    fl_dq_oe_d = 1'b0;
    fl_ce_n_d  = 1'b1;
    fl_oe_n_d  = 1'b1;
    fl_we_n_d  = 1'b1;
    case (state_d)
      StSetup, StWe, StHold: begin
        {fl_a_d, fl_dq_o_d} = entry;
        fl_ce_n_d  = 1'b0;
        fl_dq_oe_d = 1'b1;
        fl_we_n_d  = (state_d != StWe);
      end
      StPollRd: begin
        fl_a_d    = poll_target(erase_d, addr_d);
        fl_ce_n_d = 1'b0;
        fl_oe_n_d = 1'b0;
      end
      StPollChk: begin
        fl_a_d    = poll_target(erase_d, addr_d);
        fl_ce_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      erase_q    <= 1'b0;
      step_q     <= '0;
      dq7_q      <= 1'b0;
      dq5_q      <= 1'b0;
      dq5_seen_q <= 1'b0;
      tmo_q      <= '0;
      bus_req_q  <= 1'b0;
      fl_a_q     <= '0;
      fl_dq_o_q  <= '0;
      fl_dq_oe_q <= 1'b0;
      fl_ce_n_q  <= 1'b1;
      fl_oe_n_q  <= 1'b1;
      fl_we_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_q     <= done_d;
      erase_q    <= erase_d;
      step_q     <= step_d;
      dq7_q      <= dq7_d;
      dq5_q      <= dq5_d;
      dq5_seen_q <= dq5_seen_d;
      tmo_q      <= tmo_d;
      bus_req_q  <= bus_req_d;
      fl_a_q     <= fl_a_d;
      fl_dq_o_q  <= fl_dq_o_d;
      fl_dq_oe_q <= fl_dq_oe_d;
      fl_ce_n_q  <= fl_ce_n_d;
      fl_oe_n_q  <= fl_oe_n_d;
      fl_we_n_q  <= fl_we_n_d;
    end
  end

  // CMD is a write-only trigger and reads back as zero.
  always_comb begin
    case (reg_a)
      3'd0:    reg_rdata = addr_q[7:0];
      3'd1:    reg_rdata = addr_q[15:8];
      3'd2:    reg_rdata = {5'b0, addr_q[18:16]};
      3'd3:    reg_rdata = data_q;
      3'd5:    reg_rdata = {5'b0, done_q, err_q, busy_q};
      default: reg_rdata = 8'h00;
    endcase
  end

  assign bus_req  = bus_req_q;
  assign fl_a     = fl_a_q;
  assign fl_dq_o  = fl_dq_o_q;
  assign fl_dq_oe = fl_dq_oe_q;
  assign fl_ce_n  = fl_ce_n_q;
  assign fl_oe_n  = fl_oe_n_q;
  assign fl_we_n  = fl_we_n_q;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Bench for flash_prog_seq: flash polling model, per-cycle bus-protocol checker,
// and directed program/erase/error/reset scenarios.
module tb_flash_prog_seq;

  logic        phi2 = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr = 1'b0;
  logic [2:0]  reg_a = '0;
  logic [7:0]  reg_wdata = '0;
  logic [7:0]  reg_rdata;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [18:0] fl_a;
  logic [7:0]  fl_dq_o;
  logic        fl_dq_oe;
  logic [7:0]  fl_dq_i;
  logic        fl_ce_n, fl_oe_n, fl_we_n;

  always #5 phi2 = ~phi2;

  flash_prog_seq dut (
    .phi2(phi2), .rst(rst), .reg_wr(reg_wr), .reg_a(reg_a), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .bus_req(bus_req), .bus_gnt(bus_gnt), .fl_a(fl_a),
    .fl_dq_o(fl_dq_o), .fl_dq_oe(fl_dq_oe), .fl_dq_i(fl_dq_i), .fl_ce_n(fl_ce_n),
    .fl_oe_n(fl_oe_n), .fl_we_n(fl_we_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Flash model: each read cycle consumes the next scripted status byte.
  logic [7:0] resp [0:255];
  int resp_len = 1;
  int poll_idx = 0;
  int poll_base = 0;

  always @(posedge phi2) if (!fl_oe_n) poll_idx <= poll_idx + 1;

  function automatic logic [7:0] resp_at(input int k);
    int j;
    j = (k >= resp_len) ? resp_len - 1 : k;
    if (j < 0) j = 0;
    return resp[j];
  endfunction

  always_comb fl_dq_i = fl_oe_n ? 8'hFF : resp_at(poll_idx - poll_base);

  task automatic fill_resp(input int n_busy, input logic [7:0] busy_v, input logic [7:0] fin_v);
    for (int i = 0; i < n_busy; i++) resp[i] = busy_v;
    resp[n_busy] = fin_v;
    resp_len = n_busy + 1;
  endtask

  // Per-cycle protocol checker and WE-pulse logger.
  logic [26:0] we_log [$];
  logic [26:0] exp_q [$];
  logic [18:0] exp_tgt = '0;
  logic        prev_we = 1'b0;
  logic        prev_setup = 1'b0;
  logic [26:0] prev_ad = '0;

  always @(negedge phi2) begin
    if (rst) begin
      prev_we    = 1'b0;
      prev_setup = 1'b0;
    end else begin
      if (fl_ce_n) begin
        chk("idle_strobes", {fl_we_n, fl_oe_n, fl_dq_oe}, 3'b110);
        chk("idle_addr", fl_a, 0);
      end else begin
        chk("bus_owned", bus_req, 1);
        if (fl_dq_oe) begin
          chk("wr_oe_n", fl_oe_n, 1);
          if (!fl_we_n) begin
            chk("we_after_setup", prev_setup, 1);
            chk("we_stable", {fl_a, fl_dq_o}, prev_ad);
            we_log.push_back({fl_a, fl_dq_o});
          end else if (prev_we) begin
            chk("hold_stable", {fl_a, fl_dq_o}, prev_ad);
          end
        end else begin
          chk("rd_we_n", fl_we_n, 1);
          chk("poll_addr", fl_a, exp_tgt);
        end
      end
      if (prev_we) chk("hold_after_we", {fl_ce_n, fl_dq_oe, fl_we_n}, 3'b011);
      prev_setup = !fl_ce_n && fl_dq_oe && fl_we_n && !prev_we;
      prev_we    = !fl_we_n;
      prev_ad    = {fl_a, fl_dq_o};
    end
  end

  logic [18:0] m_addr = '0;
  logic [7:0]  m_data = '0;

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge phi2);
    reg_wr = 1'b1; reg_a = a; reg_wdata = d;
    @(posedge phi2); #1;
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge phi2);
    reg_a = a;
    #1 d = reg_rdata;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic set_addr(input logic [18:0] a);
    wr(3'd0, a[7:0]);
    wr(3'd1, a[15:8]);
    wr(3'd2, {5'b0, a[18:16]});
    m_addr = a;
  endtask

  task automatic chk_addr(input string name);
    chk_reg({name, "_addr_l"}, 3'd0, m_addr[7:0]);
    chk_reg({name, "_addr_m"}, 3'd1, m_addr[15:8]);
    chk_reg({name, "_addr_h"}, 3'd2, {5'b0, m_addr[18:16]});
  endtask

  // Expected outcome of polling from the DQ7/DQ5 rules applied to the scripted bytes.
  task automatic poll_model(input logic exp7, output int polls, output logic ok);
    logic       seen;
    logic [7:0] v;
    seen = 1'b0; ok = 1'b0; polls = 0;
    for (int k = 0; k < 256; k++) begin
      v = resp_at(k);
      polls = k + 1;
      if (v[7] == exp7) begin ok = 1'b1; break; end
      if (seen) break;
      if (v[5]) seen = 1'b1;
    end
  endtask

  task automatic build_exp(input logic erase);
    exp_q.delete();
    exp_q.push_back({19'h05555, 8'hAA});
    exp_q.push_back({19'h02AAA, 8'h55});
    if (erase) begin
      exp_q.push_back({19'h05555, 8'h80});
      exp_q.push_back({19'h05555, 8'hAA});
      exp_q.push_back({19'h02AAA, 8'h55});
      exp_q.push_back({m_addr[18:16], 16'h0000, 8'h30});
    end else begin
      exp_q.push_back({19'h05555, 8'hA0});
      exp_q.push_back({m_addr, m_data});
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [7:0] st;
    st = 8'h01;
    for (int i = 0; i < budget; i++) begin
      rd(3'd5, st);
      if (!st[0]) break;
    end
    chk({name, "_busy_clears"}, st[0], 0);
  endtask

  // Runs one program (erase=0, data d) or erase operation and checks it end to end.
  task automatic op(input string name, input logic erase, input logic [7:0] d, input int gnt_wait);
    int   polls;
    logic ok;
    logic exp7;
    m_data = erase ? m_data : d;
    exp7   = erase ? 1'b1 : m_data[7];
    poll_model(exp7, polls, ok);
    build_exp(erase);
    exp_tgt = erase ? {m_addr[18:16], 16'h0000} : m_addr;
    we_log.delete();
    poll_base = poll_idx;
    if (gnt_wait > 0) bus_gnt = 1'b0;
    if (erase) wr(3'd4, 8'h30); else wr(3'd3, m_data);
    chk_reg({name, "_busy"}, 3'd5, 8'h01);
    if (gnt_wait > 0) begin
      wr(3'd3, ~m_data);
      for (int i = 0; i < gnt_wait; i++) begin
        @(negedge phi2);
        chk({name, "_wait_req"}, {bus_req, fl_ce_n, fl_we_n}, 3'b111);
      end
      chk_reg({name, "_data_kept"}, 3'd3, m_data);
      bus_gnt = 1'b1;
    end
    wait_idle(name, 3000);
    chk({name, "_we_count"}, we_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < we_log.size(); i++)
      chk({name, "_we_pulse"}, we_log[i], exp_q[i]);
    chk({name, "_polls"}, poll_idx - poll_base, polls);
    chk_reg({name, "_status"}, 3'd5, ok ? 8'h04 : 8'h02);
    if (ok && !erase) m_addr = m_addr + 19'd1;
    chk_addr(name);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) resp[i] = 8'h00;

    // Reset, including a register write that reset must override.
    @(posedge phi2); #1;
    wr(3'd0, 8'hAA);
    @(posedge phi2); #1;
    rst = 1'b0;
    chk("rst_outputs", {bus_req, fl_ce_n, fl_oe_n, fl_we_n, fl_dq_oe}, 5'b01110);
    chk("rst_bus", {fl_a, fl_dq_o}, 0);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 8'h00);

    // Program 0x5A @ 0x12345; DQ7 of 0x00 already equals DATA[7].
    set_addr(19'h12345);
    fill_resp(2, 8'h00, 8'h5A);
    op("prog_5a", 1'b0, 8'h5A, 0);
    chk("prog_5a_last", we_log.size() > 0 ? we_log[we_log.size()-1] : 0, {19'h12345, 8'h5A});
    chk("prog_5a_next", m_addr, 19'h12346);

    // Program 0xA5: two busy polls with DQ7=0, third returns the data.
    fill_resp(2, 8'h00, 8'hA5);
    op("prog_a5", 1'b0, 8'hA5, 0);
    chk("prog_a5_polls", poll_idx - poll_base, 3);

    // Address wrap at the top of the device.
    set_addr(19'h7FFFF);
    fill_resp(0, 8'h00, 8'h80);
    op("prog_wrap", 1'b0, 8'h80, 0);
    chk("prog_wrap_addr", m_addr, 19'h00000);

    // Unknown command is ignored.
    set_addr(19'h51234);
    we_log.delete();
    wr(3'd4, 8'h31);
    repeat (5) @(negedge phi2);
    chk("bad_cmd_pulses", we_log.size(), 0);
    chk_reg("bad_cmd_status", 3'd5, 8'h04);

    // Sector erase of sector 5 with 100 busy polls.
    fill_resp(100, 8'h00, 8'h80);
    op("erase", 1'b1, 8'h00, 0);
    chk("erase_last", we_log.size() > 0 ? we_log[we_log.size()-1] : 0, {19'h50000, 8'h30});
    chk("erase_polls", poll_idx - poll_base, 101);

    // DQ5 timeout: mismatch on two consecutive polls flags err.
    set_addr(19'h00100);
    fill_resp(2, 8'h20, 8'h80);
    op("dq5_err", 1'b0, 8'h80, 0);
    wr(3'd5, 8'h02);
    chk_reg("err_clear", 3'd5, 8'h00);

    // Grant withheld for 50 cycles; DATA write during the wait is dropped.
    fill_resp(0, 8'h00, 8'h3C);
    op("gnt_wait", 1'b0, 8'h3C, 50);

    // Reset in the WE cycle of the third command write.
    set_addr(19'h0ABCD);
    fill_resp(0, 8'h00, 8'h77);
    wr(3'd3, 8'h77);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 3; i++) begin
      @(negedge phi2);
      if (!fl_we_n) cnt++;
    end
    chk("rst_mid_reached", cnt, 3);
    rst = 1'b1;
    @(posedge phi2); #1;
    chk("rst_mid_outputs", {fl_we_n, fl_ce_n, bus_req, fl_dq_oe}, 4'b1100);
    for (int i = 0; i < 8; i++) chk_reg("rst_mid_reg", 3'(i), 8'h00);
    @(posedge phi2); #1;
    rst = 1'b0;
    repeat (3) @(negedge phi2);
    chk("rst_mid_quiet", {bus_req, fl_ce_n}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flash_prog_seq.md
FLASH_PROG_SEQ -- requirements
Module: flash_prog_seq

Interface
REQ-001 Clock and reset: phi2 is the single clock; rst is synchronous, active-high.
REQ-002 Port: phi2  input  1  clock; all state changes on posedge phi2.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: reg_wr  input  1  one-cycle register write strobe from the CCTL decode at $D5C0..$D5C7.
REQ-005 Port: reg_a  input  3  register index.
REQ-006 Port: reg_wdata  input  8  register write data.
REQ-007 Port: reg_rdata  output  8  combinational read of the indexed register.
REQ-008 Port: bus_req  output  1  request for ownership of the ROM bus.
REQ-009 Port: bus_gnt  input  1  ROM bus granted by the cartridge mapper.
REQ-010 Port: fl_a  output  19  flash address.
REQ-011 Port: fl_dq_o  output  8  flash write data.
REQ-012 Port: fl_dq_oe  output  1  drive fl_dq_o onto the flash data bus.
REQ-013 Port: fl_dq_i  input  8  flash read data.
REQ-014 Port: fl_ce_n, fl_oe_n, fl_we_n  output  1 each  flash strobes, active-low.
REQ-015 Registers: 0 ADDR_L, 1 ADDR_M, 2 ADDR_H[2:0], 3 DATA (write starts byte program), 4 CMD (0x30 starts sector erase), 5 STATUS (bit0 busy, bit1 err, bit2 done); indices 6 and 7 read 0x00.

Function
REQ-016 States: IDLE, REQ, SETUP, WE, HOLD, POLL_RD, POLL_CHK, FINISH.
REQ-017 In IDLE, a DATA write latches data, sets busy, clears done, and enters REQ on the next cycle.
REQ-018 In IDLE, a CMD=0x30 write sets busy, clears done, and enters REQ; any other CMD value is ignored.
REQ-019 In REQ, bus_req is 1 and the FSM holds until bus_gnt=1; bus_req stays 1 until FINISH.
REQ-020 Each bus write cycle is SETUP, then WE, then HOLD, one phi2 each; fl_ce_n=0 and fl_dq_oe=1 in all three; fl_we_n=0 only in WE; fl_oe_n=1.
REQ-021 Program sequence (4 cycles): AA@5555, 55@2AAA, A0@5555, DATA@addr.
REQ-022 Erase sequence (6 cycles): AA@5555, 55@2AAA, 80@5555, AA@5555, 55@2AAA, 30@{addr[18:16],16'h0}.
REQ-023 Command addresses are zero-extended to 19 bits.
REQ-024 POLL_RD drives fl_ce_n=0, fl_oe_n=0, fl_dq_oe=0, fl_a=target; POLL_CHK samples fl_dq_i registered at the end of POLL_RD.
REQ-025 Expected DQ7 is DATA[7] for program and 1 for erase.
REQ-026 Polling: DQ7 equal to expected -> FINISH with done=1; DQ7 unequal and DQ5=0 -> back to POLL_RD.
REQ-027 DQ5=1 -> one further POLL_RD; if DQ7 still mismatches -> FINISH with err=1.
REQ-028 A 21-bit timeout counter clears on entry to POLL_RD from the write sequence; saturation -> FINISH with err=1.
REQ-029 FINISH lasts one cycle: busy=0, bus_req=0, strobes inactive; then IDLE.
REQ-030 After a successful program, addr increments by 1 modulo 2^19 (0x7FFFF wraps to 0x00000); erase leaves addr unchanged.
REQ-031 Writes to ADDR/DATA/CMD while busy=1 are ignored.
REQ-032 A write to STATUS with bit1=1 clears err at any time; other STATUS bits are read-only.
REQ-033 If bus_gnt drops while the FSM is outside IDLE/REQ, the FSM aborts to FINISH with err=1.
REQ-034 Outside SETUP..POLL_CHK: fl_ce_n=1, fl_we_n=1, fl_oe_n=1, fl_dq_oe=0, fl_a=0.

Reset
REQ-035 rst=1 forces IDLE; clears addr, DATA, busy, err and done; bus_req=0, fl_dq_oe=0, all strobes=1, fl_a=0, fl_dq_o=0.
REQ-036 rst takes precedence over reg_wr in the same cycle; rst mid-sequence aborts immediately without completing the current flash cycle.

Verification
REQ-037 ADDR=0x12345, DATA=0x5A, gnt tied 1, model returns DQ7=0 twice then 0x5A -> exactly 4 WE pulses (AA/5555, 55/2AAA, A0/5555, 5A/12345), done=1, addr=0x12346.
REQ-038 ADDR=0x7FFFF, program success -> addr reads 0x00000.
REQ-039 CMD=0x30, ADDR_H=5 -> 6 WE pulses ending 30@0x50000; DQ7=0 for 100 polls then 1 -> done=1, addr unchanged.
REQ-040 Model returns DQ5=1, DQ7 mismatched on two consecutive polls -> err=1, busy=0; STATUS write 0x02 -> err=0.
REQ-041 bus_gnt held 0 for 50 cycles -> bus_req=1, no strobe activity; DATA write during wait ignored; gnt=1 -> sequence proceeds with the original data.
REQ-042 rst asserted during the WE cycle of the third command -> next cycle fl_we_n=1, busy=0, bus_req=0, all registers 0.
